// File: rtl/interl_pkg.sv
// interl_pkg: constants and types shared by the interleaver feed scheduler
// and the interleaver itself (packet length, counter width, PRBS-15 fill setup).
package interl_pkg;

    localparam int PACK_LEN = 4608;
    localparam int CNT_W    = 13;
    localparam int PRMB_LEN = 128;

    // PRBS-15 fill generator, polynomial x^15 + x^14 + 1
    localparam int                PRBS_W      = 15;
    localparam int                PRBS_TAP_HI = 14;
    localparam int                PRBS_TAP_LO = 13;
    localparam logic [PRBS_W-1:0] PRBS_SEED   = 15'h7FFF;

    typedef enum logic [1:0] {
        ARB,
        STREAM,
        GUARD
    } sched_state_t;

endpackage

// File: rtl/interl_prbs15.sv
// interl_prbs15: PRBS-15 (x^15 + x^14 + 1) fill-data generator.
// The output bit is the feedback bit, which is also shifted in on each enable.
// A load restores the all-ones seed so every fill packet starts identically.
module interl_prbs15
    import interl_pkg::*;
(
    input  logic iclk,
    input  logic irst,
    input  logic en,
    input  logic load,
    output logic fill_bit
);

    logic [PRBS_W-1:0] lfsr;

    assign fill_bit = lfsr[PRBS_TAP_HI] ^ lfsr[PRBS_TAP_LO];

    // Shift register: reload the seed at packet start, advance once per fill bit
    always_ff @(posedge iclk or negedge irst) begin
        if (!irst) begin
            lfsr <= PRBS_SEED;
        end else if (load) begin
            lfsr <= PRBS_SEED;
        end else if (en) begin
            lfsr <= {lfsr[PRBS_W-2:0], fill_bit};
        end
    end

endmodule

// File: rtl/interl_feed_sched.sv
// interl_feed_sched: packet-level round-robin scheduler feeding the interleaver
// write port from two bit-serial sources (0: FEC payload, 1: service frames).
// Whole packets are granted, followed by a guard gap so the interleaver can
// update its bank state. Bits pass through a two-stage pipeline
// (req -> source bit -> registered output).
// Optional feature: define INTL_FILL_EN to emit PRBS-15 fill packets when the
// interleaver is starved for FILL_TIMEOUT cycles.
module interl_feed_sched
    import interl_pkg::*;
#(
    parameter int GUARD_LEN    = 4,
    parameter int FILL_TIMEOUT = 1024
) (
    input  logic       iclk,
    input  logic       irst,
    input  logic       s0_rdy,
    input  logic       s1_rdy,
    output logic       s0_req,
    output logic       s1_req,
    input  logic       s0_val,
    input  logic       s1_val,
    input  logic       s0_dat,
    input  logic       s1_dat,
    input  logic       ireq,
    output logic       osop,
    output logic       oval,
    output logic       odat,
    output logic [1:0] ogrant,
    output logic       ofill,
    output logic       oerr
);

    sched_state_t     state;
    sched_state_t     state_nxt;
    logic [CNT_W-1:0] cnt;

    logic cur_src;
    logic cur_fill;
    logic rr_ptr;

    logic grant_go;
    logic grant_src;
    logic grant_fill;
    logic starve_hit;
    logic fill_bit;

    logic act_d;
    logic sop_d;
    logic last_d;
    logic src_d;
    logic fill_d;
    logic olast;

    logic sel_val;
    logic sel_dat;

    assign sel_val = src_d ? s1_val : s0_val;
    assign sel_dat = src_d ? s1_dat : s0_dat;

    // FSM state register
    always_ff @(posedge iclk or negedge irst) begin
        if (!irst) begin
            state <= ARB;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state and arbitration decision; inputs are only looked at in ARB
    always_comb begin
        state_nxt  = state;
        grant_go   = 1'b0;
        grant_src  = 1'b0;
        grant_fill = 1'b0;
        unique case (state)
            ARB: begin
                if (ireq) begin
                    if (s0_rdy && s1_rdy) begin
                        grant_go  = 1'b1;
                        grant_src = rr_ptr;
                    end else if (s0_rdy) begin
                        grant_go  = 1'b1;
                        grant_src = 1'b0;
                    end else if (s1_rdy) begin
                        grant_go  = 1'b1;
                        grant_src = 1'b1;
                    end else if (starve_hit) begin
                        grant_go   = 1'b1;
                        grant_fill = 1'b1;
                    end
                end
                if (grant_go) begin
                    state_nxt = STREAM;
                end
            end
            STREAM: begin
                if (cnt == CNT_W'(PACK_LEN - 1)) begin
                    state_nxt = GUARD;
                end
            end
            GUARD: begin
                if (cnt == CNT_W'(GUARD_LEN - 1)) begin
                    state_nxt = ARB;
                end
            end
            default: begin
                state_nxt = ARB;
            end
        endcase
    end

    // FSM outputs: pull requests go only to the owning source, never during fill
    always_comb begin
        s0_req = 1'b0;
        s1_req = 1'b0;
        if (state == STREAM && !cur_fill) begin
            s0_req = ~cur_src;
            s1_req = cur_src;
        end
    end

    // Shared bit/guard counter, packet ownership and round-robin pointer
    always_ff @(posedge iclk or negedge irst) begin
        if (!irst) begin
            cnt      <= '0;
            cur_src  <= 1'b0;
            cur_fill <= 1'b0;
            rr_ptr   <= 1'b0;
        end else begin
            if (state_nxt != state) begin
                cnt <= '0;
            end else if (state != ARB) begin
                cnt <= cnt + CNT_W'(1);
            end
            if (grant_go) begin
                cur_src  <= grant_src;
                cur_fill <= grant_fill;
                if (!grant_fill) begin
                    rr_ptr <= ~grant_src;
                end
            end
        end
    end

    // First pipeline stage: tracks which bit the source is returning this cycle
    always_ff @(posedge iclk or negedge irst) begin
        if (!irst) begin
            act_d  <= 1'b0;
            sop_d  <= 1'b0;
            last_d <= 1'b0;
            src_d  <= 1'b0;
            fill_d <= 1'b0;
        end else begin
            act_d  <= (state == STREAM);
            sop_d  <= (state == STREAM) && (cnt == '0);
            last_d <= (state == STREAM) && (cnt == CNT_W'(PACK_LEN - 1));
            src_d  <= cur_src;
            fill_d <= cur_fill;
        end
    end

    // Output stage: a missing source bit is sent as 0 so the packet keeps its length
    always_ff @(posedge iclk or negedge irst) begin
        if (!irst) begin
            oval  <= 1'b0;
            osop  <= 1'b0;
            odat  <= 1'b0;
            olast <= 1'b0;
            oerr  <= 1'b0;
        end else begin
            oval  <= act_d;
            osop  <= sop_d;
            olast <= last_d;
            odat  <= act_d & (fill_d ? fill_bit : (sel_val & sel_dat));
            if (act_d && !fill_d && !sel_val) begin
                oerr <= 1'b1;
            end
        end
    end

    // Owner indication: set at grant, dropped once the last bit has left the output
    always_ff @(posedge iclk or negedge irst) begin
        if (!irst) begin
            ogrant <= 2'b00;
        end else if (grant_go) begin
            ogrant <= grant_fill ? 2'b00 : (grant_src ? 2'b10 : 2'b01);
        end else if (olast) begin
            ogrant <= 2'b00;
        end
    end

`ifdef INTL_FILL_EN
    localparam int STARVE_W = $clog2(FILL_TIMEOUT);

    logic [STARVE_W-1:0] starve_cnt;
    logic                ofill_q;

    assign starve_hit = (starve_cnt == STARVE_W'(FILL_TIMEOUT - 1));
    assign ofill      = ofill_q;

    // Starvation counter: interleaver wants data but neither source has a packet
    always_ff @(posedge iclk or negedge irst) begin
        if (!irst) begin
            starve_cnt <= '0;
        end else if (grant_go || (state == ARB && !ireq)) begin
            starve_cnt <= '0;
        end else if (state == ARB && !s0_rdy && !s1_rdy) begin
            starve_cnt <= starve_cnt + STARVE_W'(1);
        end
    end

    // Fill indication follows the same set/clear timing as the owner indication
    always_ff @(posedge iclk or negedge irst) begin
        if (!irst) begin
            ofill_q <= 1'b0;
        end else if (grant_go) begin
            ofill_q <= grant_fill;
        end else if (olast) begin
            ofill_q <= 1'b0;
        end
    end

    interl_prbs15 u_prbs (
        .iclk     (iclk),
        .irst     (irst),
        .en       (act_d & fill_d),
        .load     (grant_go & grant_fill),
        .fill_bit (fill_bit)
    );
`else
    assign starve_hit = 1'b0;
    assign fill_bit   = 1'b0;
    assign ofill      = 1'b0;
`endif

endmodule

// File: tb/tb_interl_feed_sched.sv
// tb_interl_feed_sched: scoreboard bench for interl_feed_sched.
// Source models answer each req one cycle later and push the expected output
// bit; a monitor pops and compares whenever oval is high.
// Fill-packet scenario is built only when INTL_FILL_EN is defined.
module tb_interl_feed_sched;
    import interl_pkg::*;

    localparam int GUARD_CYC  = 4;
    localparam int FILL_TMO   = 1024;
    localparam int PKT_PERIOD = PACK_LEN + GUARD_CYC + 1;

    logic       iclk   = 1'b0;
    logic       irst   = 1'b1;
    logic       s0_rdy = 1'b0;
    logic       s1_rdy = 1'b0;
    logic       s0_val = 1'b0;
    logic       s1_val = 1'b0;
    logic       s0_dat = 1'b0;
    logic       s1_dat = 1'b0;
    logic       ireq   = 1'b0;
    logic       s0_req;
    logic       s1_req;
    logic       osop;
    logic       oval;
    logic       odat;
    logic [1:0] ogrant;
    logic       ofill;
    logic       oerr;

    interl_feed_sched #(
        .GUARD_LEN    (GUARD_CYC),
        .FILL_TIMEOUT (FILL_TMO)
    ) dut (
        .iclk   (iclk),
        .irst   (irst),
        .s0_rdy (s0_rdy),
        .s1_rdy (s1_rdy),
        .s0_req (s0_req),
        .s1_req (s1_req),
        .s0_val (s0_val),
        .s1_val (s1_val),
        .s0_dat (s0_dat),
        .s1_dat (s1_dat),
        .ireq   (ireq),
        .osop   (osop),
        .oval   (oval),
        .odat   (odat),
        .ogrant (ogrant),
        .ofill  (ofill),
        .oerr   (oerr)
    );

    always #5 iclk = ~iclk;

    int cyc = 0;
    always @(posedge iclk) cyc++;

    // expected entry: {osop, odat, ogrant[1:0], ofill}
    logic [4:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int oval_cnt = 0;
    int sop_cnt = 0;
    int sop_cyc = 0;
    int drop0_bit = -1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic applyStimulus(input logic r0, input logic r1, input logic rq);
        s0_rdy = r0;
        s1_rdy = r1;
        ireq   = rq;
    endtask

    // Bounded wait at negedges; sel picks the condition
    task automatic waitSignal(input int sel, input int budget, input string name);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < budget && !hit; i++) begin
            @(negedge iclk);
            case (sel)
                0:       hit = (s0_req === 1'b1);
                1:       hit = (s1_req === 1'b1);
                2:       hit = (s0_req === 1'b1) || (s1_req === 1'b1);
                3:       hit = (s0_req === 1'b0) && (s1_req === 1'b0);
                4:       hit = (ogrant === 2'b00);
                5:       hit = (ofill === 1'b1);
                default: hit = (ofill === 1'b0);
            endcase
        end
        if (!hit) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s: got timeout after %0d cycles, expected condition %0d", name, budget, sel);
        end
    endtask

    function automatic logic patBit(input int src, input int idx);
        int v;
        v = idx * 7 + src * 3 + (idx >> 5);
        return v[2];
    endfunction

    // Source models: answer the req seen at the previous negedge, push expected bit
    logic pend0 = 1'b0;
    logic pend1 = 1'b0;
    int   idx0 = 0;
    int   idx1 = 0;
    always @(negedge iclk) begin
        if (!irst) begin
            pend0 = 1'b0; pend1 = 1'b0; idx0 = 0; idx1 = 0;
            s0_val = 1'b0; s0_dat = 1'b0; s1_val = 1'b0; s1_dat = 1'b0;
        end else begin
            s0_val = 1'b0; s0_dat = 1'b0; s1_val = 1'b0; s1_dat = 1'b0;
            if (pend0) begin
                if (idx0 == drop0_bit) begin
                    s0_dat = 1'b1;
                    exp_q.push_back({idx0 == 0, 1'b0, 2'b01, 1'b0});
                end else begin
                    s0_val = 1'b1;
                    s0_dat = patBit(0, idx0);
                    exp_q.push_back({idx0 == 0, s0_dat, 2'b01, 1'b0});
                end
                idx0 = (idx0 == PACK_LEN - 1) ? 0 : idx0 + 1;
            end
            if (pend1) begin
                s1_val = 1'b1;
                s1_dat = patBit(1, idx1);
                exp_q.push_back({idx1 == 0, s1_dat, 2'b10, 1'b0});
                idx1 = (idx1 == PACK_LEN - 1) ? 0 : idx1 + 1;
            end
            pend0 = s0_req;
            pend1 = s1_req;
        end
    end

    // Monitor: compare every output bit against the scoreboard head
    logic       oval_prev = 1'b0;
    logic [4:0] exp_e;
    always @(negedge iclk) begin
        if (!irst) begin
            oval_prev = 1'b0;
        end else begin
            if (oval === 1'b1) begin
                oval_cnt++;
                if (osop === 1'b1) begin
                    sop_cnt++;
                    sop_cyc = cyc;
                end
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL out_unexpected: got oval=1 at cycle %0d, expected no bit", cyc);
                end else begin
                    exp_e = exp_q.pop_front();
                    checkOutput("out_bit", {27'd0, osop, odat, ogrant, ofill}, {27'd0, exp_e});
                end
            end else if (oval_prev) begin
                checkOutput("grant_clear", {30'd0, ogrant}, 32'd0);
            end
            oval_prev = oval;
        end
    end

    initial begin
        int t_req;
        int reqs_seen;
        int rise_src[4];
        int rise_cyc[4];
        int c_rel;
        logic [14:0] lfsr;
        logic [14:0] first15;
        logic fb;

        // Reset state
        applyStimulus(1'b0, 1'b0, 1'b0);
        #3 irst = 1'b0;
        #1;
        checkOutput("rst_s0_req", s0_req, 0);
        checkOutput("rst_s1_req", s1_req, 0);
        checkOutput("rst_osop", osop, 0);
        checkOutput("rst_oval", oval, 0);
        checkOutput("rst_odat", odat, 0);
        checkOutput("rst_ogrant", ogrant, 0);
        checkOutput("rst_ofill", ofill, 0);
        checkOutput("rst_oerr", oerr, 0);
        @(negedge iclk);
        @(negedge iclk);
        irst = 1'b1;

        // Single source packet
        $display("[TB] single source packet");
        oval_cnt = 0; sop_cnt = 0; sop_cyc = 0;
        applyStimulus(1'b1, 1'b0, 1'b1);
        waitSignal(0, 10, "A_s0_req");
        t_req = cyc;
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("A_s1_req_idle", s1_req, 0);
        checkOutput("A_grant", ogrant, 2'b01);
        waitSignal(4, PACK_LEN + 20, "A_done");
        checkOutput("A_bit_count", oval_cnt, PACK_LEN);
        checkOutput("A_sop_count", sop_cnt, 1);
        checkOutput("A_sop_latency", sop_cyc - t_req, 2);
        checkOutput("A_queue_empty", exp_q.size(), 0);
        checkOutput("A_oerr", oerr, 0);

        // Missing val at bit 1000
        $display("[TB] dropped source bit");
        oval_cnt = 0;
        drop0_bit = 1000;
        applyStimulus(1'b1, 1'b0, 1'b1);
        waitSignal(0, 20, "D_s0_req");
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("D_oerr_before", oerr, 0);
        waitSignal(4, PACK_LEN + 20, "D_done");
        drop0_bit = -1;
        checkOutput("D_bit_count", oval_cnt, PACK_LEN);
        checkOutput("D_oerr_set", oerr, 1);
        checkOutput("D_queue_empty", exp_q.size(), 0);

        // ireq low blocks arbitration
        $display("[TB] ireq gating");
        applyStimulus(1'b0, 1'b1, 1'b0);
        reqs_seen = 0;
        repeat (100) begin
            @(negedge iclk);
            if (s0_req === 1'b1 || s1_req === 1'b1) reqs_seen++;
        end
        checkOutput("C_no_req", reqs_seen, 0);
        ireq = 1'b1;
        @(negedge iclk);
        checkOutput("C_s1_req_latency", s1_req, 1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("C_grant", ogrant, 2'b10);

        // Reset in the middle of the packet
        $display("[TB] mid-packet reset");
        repeat (2000) @(negedge iclk);
        checkOutput("E_oerr_sticky", oerr, 1);
        checkOutput("E_oval_mid", oval, 1);
        #2 irst = 1'b0;
        #1;
        checkOutput("E_s0_req", s0_req, 0);
        checkOutput("E_s1_req", s1_req, 0);
        checkOutput("E_osop", osop, 0);
        checkOutput("E_oval", oval, 0);
        checkOutput("E_odat", odat, 0);
        checkOutput("E_ogrant", ogrant, 0);
        checkOutput("E_ofill", ofill, 0);
        checkOutput("E_oerr", oerr, 0);
        @(negedge iclk);
        #1 exp_q.delete();
        applyStimulus(1'b1, 1'b1, 1'b1);
        @(negedge iclk);
        irst = 1'b1;

        // Both sources ready: alternation and period
        $display("[TB] round robin");
        oval_cnt = 0;
        for (int k = 0; k < 4; k++) begin
            waitSignal(2, PKT_PERIOD + 20, "B_req_rise");
            rise_src[k] = (s1_req === 1'b1) ? 1 : 0;
            rise_cyc[k] = cyc;
            if (k == 3) applyStimulus(1'b0, 1'b0, 1'b1);
            waitSignal(3, PACK_LEN + 20, "B_req_fall");
        end
        checkOutput("B_order0", rise_src[0], 0);
        checkOutput("B_order1", rise_src[1], 1);
        checkOutput("B_order2", rise_src[2], 0);
        checkOutput("B_order3", rise_src[3], 1);
        checkOutput("B_s0_period", rise_cyc[2] - rise_cyc[0], 9226);
        checkOutput("B_s1_period", rise_cyc[3] - rise_cyc[1], 9226);
        waitSignal(4, 20, "B_done");
        checkOutput("B_bit_count", oval_cnt, 4 * PACK_LEN);
        checkOutput("B_oerr", oerr, 0);
        checkOutput("B_queue_empty", exp_q.size(), 0);

`ifdef INTL_FILL_EN
        // Starvation fill packet
        $display("[TB] fill packet");
        @(negedge iclk);
        #2 irst = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b1);
        #1 exp_q.delete();
        oval_cnt = 0; sop_cnt = 0; sop_cyc = 0;
        first15 = 15'h4000;
        lfsr = 15'h7FFF;
        for (int i = 0; i < PACK_LEN; i++) begin
            fb = lfsr[14] ^ lfsr[13];
            exp_q.push_back({i == 0, (i < 15) ? first15[i] : fb, 2'b00, 1'b1});
            lfsr = {lfsr[13:0], fb};
        end
        @(negedge iclk);
        irst = 1'b1;
        c_rel = cyc;
        waitSignal(5, FILL_TMO + 20, "F_fill_start");
        waitSignal(6, PACK_LEN + 20, "F_fill_end");
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("F_sop_time", sop_cyc - c_rel, 1026);
        checkOutput("F_bit_count", oval_cnt, PACK_LEN);
        checkOutput("F_sop_count", sop_cnt, 1);
        checkOutput("F_queue_empty", exp_q.size(), 0);
        checkOutput("F_no_req", {30'd0, s0_req, s1_req}, 0);
`endif

        repeat (5) @(negedge iclk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
